// File: rtl/multi_delay_buffer.sv
// Multi-channel programmable delay line. Each channel runs its own circular
// buffer in an external 2-port RAM. Delay amounts are latched on run.
// A channel configured with amount 0 bypasses the RAM with a single register stage.

module multi_delay_buffer_ch #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              running,
    input  logic [DATA_W-1:0] in_d,
    input  logic [ADDR_W-1:0] amount,
    output logic [DATA_W-1:0] out_d,
    output logic              primed,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);
    typedef enum logic [1:0] {S_IDLE, S_BYPASS, S_FILL, S_STREAM} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   amt_q;
    logic [ADDR_W-1:0]   wptr_q;
    logic [ADDR_W-1:0]   fill_cnt_q;
    logic [DATA_W-1:0]   out_q;
    logic [DATA_W-1:0]   hold_q;
    logic                rd_q;
    logic                use_ram;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next state and RAM port controls; run pre-empts everything, including RAM access
    always_comb begin
        state_d = state_q;
        wr      = 1'b0;
        rd      = 1'b0;
        if (run) begin
            state_d = (amount == '0) ? S_BYPASS : S_FILL;
        end else if (running) begin
            case (state_q)
                S_FILL: begin
                    wr = 1'b1;
                    if (fill_cnt_q == amt_q - ADDR_W'(1)) state_d = S_STREAM;
                end
                S_STREAM: begin
                    wr = 1'b1;
                    rd = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath: pointers, latched amount, bypass register and RAM read hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amt_q      <= '0;
            wptr_q     <= '0;
            fill_cnt_q <= '0;
            out_q      <= '0;
            hold_q     <= '0;
            rd_q       <= 1'b0;
        end else if (run) begin
            amt_q      <= amount;
            wptr_q     <= '0;
            fill_cnt_q <= '0;
            out_q      <= '0;
            hold_q     <= '0;
            rd_q       <= 1'b0;
        end else begin
            rd_q <= rd;
            if (rd_q) hold_q <= rd_data;
            if (wr) wptr_q <= wptr_q + ADDR_W'(1);
            if (wr && state_q == S_FILL) fill_cnt_q <= fill_cnt_q + ADDR_W'(1);
            if (running && state_q == S_BYPASS) out_q <= in_d;
        end
    end

    assign use_ram = (state_q == S_FILL) || (state_q == S_STREAM);
    // RAM data is shown directly the cycle it arrives, then held through pauses
    assign out_d   = use_ram ? (rd_q ? rd_data : hold_q) : out_q;
    assign primed  = (state_q == S_STREAM) || (state_q == S_BYPASS);
    assign wr_addr = wptr_q;
    assign wr_data = in_d;
    // Modulo wrap: amt >= 1 keeps the read slot distinct from the write slot
    assign rd_addr = wptr_q - amt_q;
endmodule

module multi_delay_buffer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int N_CH   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     running,
    input  logic [N_CH*DATA_W-1:0]   in_i,
    output logic [N_CH*DATA_W-1:0]   out_o,
    input  logic [N_CH*ADDR_W-1:0]   amount_i,
    output logic [N_CH-1:0]          primed_o,
    output logic [N_CH-1:0]          ext_2p_write_o,
    output logic [N_CH*ADDR_W-1:0]   ext_2p_addr_out_o,
    output logic [N_CH*DATA_W-1:0]   ext_2p_data_out_o,
    output logic [N_CH-1:0]          ext_2p_read_o,
    output logic [N_CH*ADDR_W-1:0]   ext_2p_addr_in_o,
    input  logic [N_CH*DATA_W-1:0]   ext_2p_data_in_i
);
    for (genvar c = 0; c < N_CH; c++) begin : gen_ch
        multi_delay_buffer_ch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .run     (run),
            .running (running),
            .in_d    (in_i[c*DATA_W +: DATA_W]),
            .amount  (amount_i[c*ADDR_W +: ADDR_W]),
            .out_d   (out_o[c*DATA_W +: DATA_W]),
            .primed  (primed_o[c]),
            .wr      (ext_2p_write_o[c]),
            .wr_addr (ext_2p_addr_out_o[c*ADDR_W +: ADDR_W]),
            .wr_data (ext_2p_data_out_o[c*DATA_W +: DATA_W]),
            .rd      (ext_2p_read_o[c]),
            .rd_addr (ext_2p_addr_in_o[c*ADDR_W +: ADDR_W]),
            .rd_data (ext_2p_data_in_i[c*DATA_W +: DATA_W])
        );
    end
endmodule

// File: tb/tb_multi_delay_buffer.sv
// Bench for multi_delay_buffer: 2 channels, 4-bit addresses, behavioural 2-port RAM.
// Each channel's expected output stream comes from a queue primed with amt zeros.

module tb_multi_delay_buffer;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int NC = 2;

    logic clk = 1'b0;
    logic rst, run, running;
    logic [NC*DW-1:0] in_i, out_o, ext_2p_data_out_o, ext_2p_data_in_i;
    logic [NC*AW-1:0] amount_i, ext_2p_addr_out_o, ext_2p_addr_in_o;
    logic [NC-1:0]    primed_o, ext_2p_write_o, ext_2p_read_o;

    always #5 clk = ~clk;

    multi_delay_buffer #(.ADDR_W(AW), .DATA_W(DW), .N_CH(NC)) dut (
        .clk(clk), .rst(rst), .run(run), .running(running),
        .in_i(in_i), .out_o(out_o), .amount_i(amount_i), .primed_o(primed_o),
        .ext_2p_write_o(ext_2p_write_o), .ext_2p_addr_out_o(ext_2p_addr_out_o),
        .ext_2p_data_out_o(ext_2p_data_out_o), .ext_2p_read_o(ext_2p_read_o),
        .ext_2p_addr_in_o(ext_2p_addr_in_o), .ext_2p_data_in_i(ext_2p_data_in_i)
    );

    // Synchronous 2-port RAM per channel, read data one cycle after read
    logic [DW-1:0] mem [NC][16];
    always @(posedge clk) begin
        for (int c = 0; c < NC; c++) begin
            if (ext_2p_write_o[c]) mem[c][ext_2p_addr_out_o[c*AW +: AW]] <= ext_2p_data_out_o[c*DW +: DW];
            if (ext_2p_read_o[c])  ext_2p_data_in_i[c*DW +: DW] <= mem[c][ext_2p_addr_in_o[c*AW +: AW]];
        end
    end

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] sbq [NC][$];
    logic [DW-1:0] exp_out [NC];
    bit            started [NC];
    int            m_amt   [NC];
    int            m_cnt   [NC];

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) begin
            sbq[c].delete();
            exp_out[c] = '0;
            started[c] = 1'b0;
            m_amt[c]   = 0;
            m_cnt[c]   = 0;
        end
    endfunction

    // One clock: drive inputs, check RAM port activity, advance scoreboard, check outputs
    task automatic tick(input logic r, input logic rn, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        logic [DW-1:0] d [NC];
        logic ew, er, ep;
        d[0] = d0; d[1] = d1;
        run = r; running = rn; in_i = {d1, d0};
        #1;
        for (int c = 0; c < NC; c++) begin
            ew = !r && rn && started[c] && m_amt[c] != 0;
            er = ew && m_cnt[c] >= m_amt[c];
            total++;
            if (ext_2p_write_o[c] !== ew) begin
                bad++; $display("FAIL wr_en ch%0d t=%0t got %b want %b", c, $time, ext_2p_write_o[c], ew);
            end
            total++;
            if (ext_2p_read_o[c] !== er) begin
                bad++; $display("FAIL rd_en ch%0d t=%0t got %b want %b", c, $time, ext_2p_read_o[c], er);
            end
            if (ew) begin
                total++;
                if (ext_2p_addr_out_o[c*AW +: AW] !== AW'(m_cnt[c])) begin
                    bad++; $display("FAIL wr_addr ch%0d t=%0t got %0d want %0d", c, $time, ext_2p_addr_out_o[c*AW +: AW], AW'(m_cnt[c]));
                end
                total++;
                if (ext_2p_data_out_o[c*DW +: DW] !== d[c]) begin
                    bad++; $display("FAIL wr_data ch%0d t=%0t got %0d want %0d", c, $time, ext_2p_data_out_o[c*DW +: DW], d[c]);
                end
            end
            if (er) begin
                total++;
                if (ext_2p_addr_in_o[c*AW +: AW] !== AW'(m_cnt[c] - m_amt[c])) begin
                    bad++; $display("FAIL rd_addr ch%0d t=%0t got %0d want %0d", c, $time, ext_2p_addr_in_o[c*AW +: AW], AW'(m_cnt[c] - m_amt[c]));
                end
                total++;
                if (ext_2p_addr_in_o[c*AW +: AW] === ext_2p_addr_out_o[c*AW +: AW]) begin
                    bad++; $display("FAIL rd_eq_wr ch%0d t=%0t addr %0d", c, $time, ext_2p_addr_in_o[c*AW +: AW]);
                end
            end
            if (r) begin
                started[c] = 1'b1;
                m_amt[c]   = int'(amount_i[c*AW +: AW]);
                m_cnt[c]   = 0;
                sbq[c].delete();
                repeat (m_amt[c]) sbq[c].push_back('0);
                exp_out[c] = '0;
            end else if (rn && started[c]) begin
                sbq[c].push_back(d[c]);
                exp_out[c] = sbq[c].pop_front();
                m_cnt[c]++;
            end
        end
        @(posedge clk); #1;
        for (int c = 0; c < NC; c++) begin
            ep = started[c] && (m_amt[c] == 0 || m_cnt[c] >= m_amt[c]);
            total++;
            if (out_o[c*DW +: DW] !== exp_out[c]) begin
                bad++; $display("FAIL out ch%0d t=%0t got %0d want %0d", c, $time, out_o[c*DW +: DW], exp_out[c]);
            end
            total++;
            if (primed_o[c] !== ep) begin
                bad++; $display("FAIL primed ch%0d t=%0t got %b want %b", c, $time, primed_o[c], ep);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; running = 1'b1; in_i = '1; amount_i = '1;
        model_reset();
        @(posedge clk); #1;
        total++;
        if (out_o !== '0 || primed_o !== '0) begin
            bad++; $display("FAIL reset_out out=%h primed=%b want 0", out_o, primed_o);
        end
        total++;
        if (ext_2p_write_o !== '0 || ext_2p_read_o !== '0 || ext_2p_addr_out_o !== '0 || ext_2p_addr_in_o !== '0) begin
            bad++; $display("FAIL reset_ram wr=%b rd=%b aout=%h ain=%h want 0", ext_2p_write_o, ext_2p_read_o, ext_2p_addr_out_o, ext_2p_addr_in_o);
        end
        rst = 1'b0;
        // running without a prior run stays idle
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, DW'(i + 7), DW'(i + 9));
    endtask

    task automatic test_bypass();
        amount_i = '0;
        tick(1'b1, 1'b0, '0, '0);
        total++;
        if (primed_o !== 2'b11) begin
            bad++; $display("FAIL bypass_primed got %b want 11", primed_o);
        end
        for (int i = 1; i <= 3; i++) begin
            tick(1'b0, 1'b1, DW'(i), DW'(i + 50));
            total++;
            if (out_o[DW-1:0] !== DW'(i)) begin
                bad++; $display("FAIL bypass_out got %0d want %0d", out_o[DW-1:0], i);
            end
        end
    endtask

    task automatic test_delay3();
        amount_i = {AW'(0), AW'(3)};
        tick(1'b1, 1'b0, '0, '0);
        for (int i = 10; i <= 14; i++) begin
            tick(1'b0, 1'b1, DW'(i), DW'(i + 200));
            if (i == 11) begin
                total++;
                if (primed_o[0] !== 1'b0) begin
                    bad++; $display("FAIL d3_primed_early got %b want 0", primed_o[0]);
                end
            end
            if (i == 12) begin
                total++;
                if (primed_o[0] !== 1'b1) begin
                    bad++; $display("FAIL d3_primed got %b want 1", primed_o[0]);
                end
            end
            if (i >= 13) begin
                total++;
                if (out_o[DW-1:0] !== DW'(i - 3)) begin
                    bad++; $display("FAIL d3_out got %0d want %0d", out_o[DW-1:0], i - 3);
                end
            end
        end
    endtask

    task automatic test_wrap();
        amount_i = {AW'(7), AW'(15)};
        tick(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, DW'(i), DW'(100 + i));
        total++;
        if (out_o[DW-1:0] !== DW'(24)) begin
            bad++; $display("FAIL wrap_last got %0d want 24", out_o[DW-1:0]);
        end
    endtask

    task automatic test_pause();
        logic [NC*DW-1:0] held;
        amount_i = {AW'(4), AW'(2)};
        tick(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, DW'(300 + i), DW'(400 + i));
        held = out_o;
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, DW'(999), DW'(999));
        total++;
        if (out_o !== held) begin
            bad++; $display("FAIL pause_hold got %h want %h", out_o, held);
        end
        for (int i = 6; i < 12; i++) tick(1'b0, 1'b1, DW'(300 + i), DW'(400 + i));
        total++;
        if (out_o[DW-1:0] !== DW'(309)) begin
            bad++; $display("FAIL pause_resume got %0d want 309", out_o[DW-1:0]);
        end
    endtask

    task automatic test_independence_restart();
        amount_i = {AW'(5), AW'(1)};
        tick(1'b1, 1'b0, '0, '0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, DW'(500 + i), DW'(700 + i));
        amount_i = {AW'(9), AW'(9)};
        for (int i = 10; i < 15; i++) tick(1'b0, 1'b1, DW'(500 + i), DW'(700 + i));
        total++;
        if (out_o !== {DW'(709), DW'(513)}) begin
            bad++; $display("FAIL indep_out got %h want %h", out_o, {DW'(709), DW'(513)});
        end
        amount_i = {AW'(0), AW'(2)};
        tick(1'b1, 1'b1, DW'(1), DW'(1));
        total++;
        if (out_o !== '0 || primed_o !== 2'b10) begin
            bad++; $display("FAIL restart out=%h primed=%b want 0/10", out_o, primed_o);
        end
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, DW'(800 + i), DW'(900 + i));
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; running = 1'b0; in_i = '0; amount_i = '0;
        model_reset();
        test_reset();
        test_bypass();
        test_delay3();
        test_wrap();
        test_pause();
        test_independence_restart();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_delay_buffer.md
Name: multi_delay_buffer

Overview:
- Multi-channel, per-channel-programmable delay line for the Versat datapath.
- Generalises the single-channel delay unit to N_CH independent channels.
- Each channel uses its own circular buffer in an external 2-port RAM. It adds an explicit fill/stream state machine, amount latching at run, and per-channel primed status.
- Sits between producer and consumer units; equalises pipeline latencies of up to 2^ADDR_W cycles per channel.

Parameters:
- ADDR_W, 6, per-channel buffer address width; depth 2^ADDR_W; max delay amount 2^ADDR_W-1.
- DATA_W, 32, sample width.
- N_CH, 2, number of independent channels (1..8).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- run  in  1  single-cycle start pulse: restarts all channels and latches amounts.
- running  in  1  accelerator active; each high cycle consumes one sample per channel.
- in_i  in  N_CH*DATA_W  channel c input at bits [c*DATA_W +: DATA_W].
- out_o  out  N_CH*DATA_W  delayed channel outputs, same packing.
- amount_i  in  N_CH*ADDR_W  per-channel delay config; sampled only on run.
- primed_o  out  N_CH  channel c in STREAM state, or in bypass mode.
- ext_2p_write_o  out  N_CH  per-channel RAM write enable.
- ext_2p_addr_out_o  out  N_CH*ADDR_W  write address.
- ext_2p_data_out_o  out  N_CH*DATA_W  write data; equals in_i slice.
- ext_2p_read_o  out  N_CH  read enable.
- ext_2p_addr_in_o  out  N_CH*ADDR_W  read address.
- ext_2p_data_in_i  in  N_CH*DATA_W  read data; synchronous RAM, valid one cycle after read.

Behaviour:
- Reset: all state cleared.
  - out_o=0, primed_o=0, all ext enables=0, addresses=0.
  - Latched amounts=0; states=IDLE.
- Per-channel state machine: IDLE, BYPASS, FILL, STREAM.
- run (highest priority, regardless of running):
  - amt_q[c]<=amount_i slice; wptr<=0; fill_cnt<=0; out slice and hold register cleared to 0; no RAM access that cycle.
  - Next state is BYPASS if amt==0, else FILL.
- running low in any state:
  - No RAM access; pointers, counters and state frozen.
  - out_o holds its value.
- IDLE: ignores running until the first run.
- BYPASS, running high: out slice <= in slice (registered); latency 1; RAM unused.
- FILL, running high:
  - write=1, addr_out=wptr, data_out=in; wptr<=wptr+1; fill_cnt<=fill_cnt+1.
  - When the write with fill_cnt==amt-1 completes, go to STREAM.
  - out_o stays 0.
- STREAM, running high:
  - Write as in FILL.
  - Also read=1, addr_in=(wptr-amt) mod 2^ADDR_W.
  - rd_q<=1 for the next cycle.
- Output in FILL/STREAM: out slice = rd_q ? ext_2p_data_in_i slice : hold_q.
  - hold_q captures the RAM data whenever rd_q=1.
  - rd_q clears on any non-read cycle.
- Latency: a sample accepted on running cycle k appears on out_o on the cycle after running cycle k+amt, i.e. a delay of amt+1 running cycles. Pauses stretch the delay uniformly.
- Pointer arithmetic: ADDR_W-bit, wraps modulo 2^ADDR_W.
  - amt>=1 guarantees read address != write address.
  - amt=2^ADDR_W-1 is the maximum; the full ring is used.
- amount_i changes mid-operation are ignored until the next run.
- run mid-STREAM discards all buffered data; output returns to 0 until re-primed.
- primed_o[c]=1 in STREAM or BYPASS, else 0.
- Channels are fully independent; the only shared inputs are clk/rst/run/running.

Test Plan:
- Reset then idle: rst pulse, running=1 without run -> out_o=0, primed_o=0, no ext writes/reads.
- Bypass: amount=0, run, then in=1,2,3 on consecutive running cycles -> out=1,2,3 one cycle later each; primed=1 right after run.
- Delay 3, ch0: run, in=10,11,12,13,14 -> out=0 for 3 cycles; then 10,11 on the cycles after inputs 13,14; primed rises after 3 writes; read addr 0 on the 4th write.
- Wrap, max depth: ADDR_W=4, amount=15, stream 40 samples of value=index -> out(t)=t-16 for t>=16; addresses wrap 15->0; never read addr==write addr.
- Pause and hold: amount=2, deassert running for 5 cycles mid-stream -> out holds last value; no RAM enables; resumes the sequence with no loss or duplication.
- Independence and restart: ch0 amt=1, ch1 amt=5 with distinct streams -> correct per-channel delays. Change amount_i mid-run -> no effect. A run pulse mid-stream -> outs go 0, primed drop, refill with new amounts.
